axil_reg_bank: RTL and testbench

Parametrised AXI4-Lite slave register bank, the successor to the single-data/single-address JTAG-to-AXI-Lite capture path. Instead of one data word and one address, it exposes NUM_REGS independently addressable registers with byte strobes, read-back, per-register write pulses, read-only status channels and error responses. It sits behind the JTAG-AXI master, or any AXI-Lite master, and drives DAC/control configuration.

---
 rtl/axil_pkg.sv | 13 +
 rtl/axil_reg_bank_if.sv | 42 ++++
 rtl/axil_wstrb_merge.sv | 22 ++
 rtl/axil_reg_bank.sv | 203 ++++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on bresp/rresp.
//   write_state_t           : write-channel FSM states.
//   read_state_t            : read-channel FSM states.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} write_state_t;
  typedef enum logic {R_IDLE, R_DATA} read_state_t;

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle for the register bank.
//   AW: awaddr, awvalid, awready
//   W : wdata, wstrb, wvalid, wready
//   B : bresp, bvalid, bready
//   AR: araddr, arvalid, arready
//   R : rdata, rresp, rvalid, rready
// The slave modport is used by axil_reg_bank, the master modport by whatever
// drives it.
interface axil_reg_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge for a strobed write.
//   old_data : current register contents
//   new_data : incoming write data
//   strb     : one bit per byte lane; 1 takes the lane from new_data
//   merged   : resulting register value
module axil_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank.
//   aclk, arst   : clock, asynchronous active-high reset
//   s_axil       : AXI4-Lite slave bus (axil_reg_bank_if.slave)
//   reg_out      : register contents, slice i = register i
//   reg_wr_pulse : one-cycle pulse the cycle after register i is written
//   reg_in       : status values returned by reads of read-only registers
// Registers are indexed by addr[ADDR_WIDTH-1:ADDR_LSB]. Indices at or above
// NUM_REGS, and writes to read-only registers, answer SLVERR. The write and
// read channels run independent two-state FSMs; all outputs are registered.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           arst,
  axil_reg_bank_if.slave                 s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_W);
  localparam int IDX_FULL_W = ADDR_WIDTH - ADDR_LSB;
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Full-width compare so that high address bits make an index out of range
  // rather than aliasing onto a low register.
  function automatic logic in_range(input logic [IDX_FULL_W-1:0] full_idx);
    return {1'b0, full_idx} < (IDX_FULL_W+1)'(NUM_REGS);
  endfunction

  logic [DATA_WIDTH-1:0] regs       [NUM_REGS];
  logic [DATA_WIDTH-1:0] reg_in_arr [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slices
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    assign reg_in_arr[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Write channel
  write_state_t          w_state;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [IDX_FULL_W-1:0] aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [IDX_FULL_W-1:0] wr_full_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign aw_hs = s_axil.awvalid && awready_q;
  assign w_hs  = s_axil.wvalid && wready_q;

  // In W_IDLE a dropped ready means that channel was already captured, so the
  // write completes on the edge where the remaining channel handshakes. The
  // just-handshaking channel is taken straight from the bus.
  assign commit = (w_state == W_IDLE) && (aw_hs || !awready_q) && (w_hs || !wready_q);

  assign wr_full_idx = aw_hs ? s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB] : aw_idx_q;
  assign wr_data     = w_hs ? s_axil.wdata : wdata_q;
  assign wr_strb     = w_hs ? s_axil.wstrb : wstrb_q;
  assign wr_idx      = wr_full_idx[IDX_W-1:0];
  assign wr_ok       = in_range(wr_full_idx) && !RO_MASK[wr_idx];
  assign wr_old      = in_range(wr_full_idx) ? regs[wr_idx] : '0;

  axil_wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_data (wr_old),
    .new_data (wr_data),
    .strb     (wr_strb),
    .merged   (wr_merged)
  );

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      w_state      <= W_IDLE;
      awready_q    <= 1'b1;
      wready_q     <= 1'b1;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      reg_wr_pulse <= '0;
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_idx_q  <= s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= s_axil.wdata;
            wstrb_q  <= s_axil.wstrb;
            wready_q <= 1'b0;
          end
          if (commit) begin
            w_state  <= W_RESP;
            bvalid_q <= 1'b1;
            if (wr_ok) begin
              regs[wr_idx]         <= wr_merged;
              reg_wr_pulse[wr_idx] <= 1'b1;
              bresp_q              <= RESP_OKAY;
            end else begin
              bresp_q <= RESP_SLVERR;
            end
          end
        end
        W_RESP: begin
          if (s_axil.bready) begin
            w_state   <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;

  // Read channel
  read_state_t           r_state;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  ar_hs;
  logic [IDX_FULL_W-1:0] rd_full_idx;
  logic [IDX_W-1:0]      rd_idx;

  assign ar_hs       = s_axil.arvalid && arready_q;
  assign rd_full_idx = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx      = rd_full_idx[IDX_W-1:0];

  // regs is sampled before the write block's update lands, so a read and a
  // write committing on the same edge return the old value.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state   <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            if (!in_range(rd_full_idx)) begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end else if (RO_MASK[rd_idx]) begin
              rdata_q <= reg_in_arr[rd_idx];
              rresp_q <= RESP_OKAY;
            end else begin
              rdata_q <= regs[rd_idx];
              rresp_q <= RESP_OKAY;
            end
          end
        end
        R_DATA: begin
          if (s_axil.rready) begin
            r_state   <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Bench for axil_reg_bank: directed scenarios followed by randomized
// reads/writes, checked against an array-based model of the register map.
module tb_axil_reg_bank;
  import axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 4;
  localparam logic [NR-1:0] RO = 4'b1000;

  logic             aclk = 1'b0;
  logic             arst;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;
  logic [NR*DW-1:0] reg_in;

  axil_reg_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axil_reg_bank #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .RO_MASK    (RO)
  ) dut (
    .aclk         (aclk),
    .arst         (arst),
    .s_axil       (bus.slave),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_in       (reg_in)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model  [NR];
  logic [DW-1:0] status [NR];

  always_comb begin
    reg_in = '0;
    for (int k = 0; k < NR; k++) reg_in[k*DW +: DW] = status[k];
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = model[k];
    return v;
  endfunction

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                               input logic [3:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic bit writable(input int i);
    if (i >= NR) return 1'b0;
    return !RO[i];
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input int i);
    if (i >= NR) return '0;
    if (RO[i]) return status[i];
    return model[i];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NR; k++) model[k] = '0;
  endtask

  // Drives one write starting at a negedge; AW and W are each delayed by the
  // given number of cycles. bready is held low for 'hold' cycles of bvalid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int w_delay, input int hold);
    bit aw_done = 0;
    bit w_done  = 0;
    bit awr, wr;
    int cyc = 0;
    int i;
    logic [1:0]    eresp;
    logic [NR-1:0] epulse;
    i = int'(addr >> 2);
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.bready = 1'b0;
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        return;
      end
      bus.awvalid = !aw_done && (cyc >= aw_delay);
      bus.wvalid  = !w_done && (cyc >= w_delay);
      awr = bus.awready;
      wr  = bus.wready;
      @(posedge aclk);
      if (bus.awvalid && awr) aw_done = 1;
      if (bus.wvalid && wr) w_done = 1;
      @(negedge aclk);
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (writable(i)) begin
      model[i] = byte_merge(model[i], data, strb);
      eresp    = RESP_OKAY;
      epulse   = NR'(1) << i;
    end else begin
      eresp  = RESP_SLVERR;
      epulse = '0;
    end
    chk("bvalid", bus.bvalid, 1'b1);
    chk("bresp", bus.bresp, eresp);
    chk("wr_pulse", reg_wr_pulse, epulse);
    chk("reg_out", reg_out, model_vec());
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      chk("bvalid_hold", bus.bvalid, 1'b1);
      chk("bresp_hold", bus.bresp, eresp);
      chk("wr_pulse_once", reg_wr_pulse, '0);
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    chk("bvalid_clear", bus.bvalid, 1'b0);
    chk("wr_pulse_clear", reg_wr_pulse, '0);
    chk("awready_back", {bus.awready, bus.wready}, 2'b11);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold);
    bit done = 0;
    bit arr;
    int cyc = 0;
    int i;
    logic [DW-1:0] edata;
    logic [1:0]    eresp;
    i = int'(addr >> 2);
    bus.araddr = addr;
    bus.rready = 1'b0;
    while (!done) begin
      if (cyc > 40) begin
        bus.arvalid = 1'b0;
        chk("rd_handshake", done, 1'b1);
        return;
      end
      bus.arvalid = 1'b1;
      arr = bus.arready;
      @(posedge aclk);
      if (arr) done = 1;
      @(negedge aclk);
      cyc++;
    end
    bus.arvalid = 1'b0;
    edata = exp_rdata(i);
    eresp = (i < NR) ? RESP_OKAY : RESP_SLVERR;
    chk("rvalid", bus.rvalid, 1'b1);
    chk("rdata", bus.rdata, edata);
    chk("rresp", bus.rresp, eresp);
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      chk("rvalid_hold", bus.rvalid, 1'b1);
      chk("rdata_hold", bus.rdata, edata);
    end
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0;
    chk("rvalid_clear", bus.rvalid, 1'b0);
    chk("arready_back", bus.arready, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_readies"}, {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk({tag, "_valids"}, {bus.bvalid, bus.rvalid}, 2'b00);
    chk({tag, "_resps"}, {bus.bresp, bus.rresp}, 4'b0000);
    chk({tag, "_rdata"}, bus.rdata, '0);
    chk({tag, "_reg_out"}, reg_out, '0);
    chk({tag, "_pulse"}, reg_wr_pulse, '0);
  endtask

  initial begin
    arst        = 1'b1;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    clear_model();
    for (int k = 0; k < NR; k++) status[k] = '0;
    repeat (2) @(negedge aclk);
    arst = 1'b0;
    @(negedge aclk);
    check_reset_state("reset");

    // Same-cycle AW/W, full strobe
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("t1_slice1", reg_out[63:32], 32'hDEADBEEF);
    axi_read(32'h4, 0);

    // W three cycles ahead of AW, partial strobe, bready held low
    axi_write(32'h8, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(32'h8, 32'h0000ABCD, 4'h3, 3, 0, 5);
    chk("t2_slice2", reg_out[95:64], 32'h1122ABCD);

    // Out of range
    axi_write(32'h10, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(32'h10, 1);

    // Read-only register
    status[3] = 32'hCAFE0001;
    axi_read(32'hC, 0);
    axi_write(32'hC, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
    chk("t4_slice3", reg_out[127:96], 32'h0);

    // Read and write to the same register committing on one edge
    axi_write(32'h0, 32'h5, 4'hF, 0, 0, 0);
    bus.awaddr  = 32'h0;
    bus.wdata   = 32'h9;
    bus.wstrb   = 4'hF;
    bus.araddr  = 32'h0;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.arvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    chk("t5_rvalid", bus.rvalid, 1'b1);
    chk("t5_old_rdata", bus.rdata, 32'h5);
    chk("t5_bvalid", bus.bvalid, 1'b1);
    model[0] = 32'h9;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    axi_read(32'h0, 0);

    // Reset while bvalid is high, then reset with only AW captured
    bus.awaddr  = 32'h8;
    bus.wdata   = 32'h77;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk("t6_bvalid_pre", bus.bvalid, 1'b1);
    arst = 1'b1;
    #1;
    check_reset_state("arst_bvalid");
    @(negedge aclk);
    arst = 1'b0;
    clear_model();
    bus.awaddr  = 32'h4;
    bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk("t6_aw_captured", bus.awready, 1'b0);
    arst = 1'b1;
    #1;
    check_reset_state("arst_aw");
    @(negedge aclk);
    arst = 1'b0;
    @(negedge aclk);
    axi_write(32'h8, 32'hA5A5A5A5, 4'hF, 0, 2, 0);
    axi_read(32'h8, 0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ({29'd0, 3'($urandom_range(0, 5))} << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        for (int k = 0; k < NR; k++) status[k] = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
